univ_shift_reg: RTL and testbench



---
 rtl/univ_shift_reg_pkg.sv | 17 +
 rtl/univ_shift_reg_bit_counter.sv | 23 ++
 rtl/univ_shift_reg.sv | 87 ++++++++
 tb/tb_univ_shift_reg.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared encodings for the universal shift register: mode select values and FSM states.
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/univ_shift_reg_bit_counter.sv
// Serialiser bit counter: sync clear beats enable; tc flags the last bit (WIDTH-1).
module univ_shift_reg_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with mode bus and LSB-first serialiser.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  output logic [WIDTH-1:0] stored,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] stored_nxt;
  logic             done_nxt;
  logic             cnt_clr, cnt_en, cnt_tc;

  univ_shift_reg_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .Clk     (Clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .tc      (cnt_tc)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      stored <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      stored <= stored_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    stored_nxt = stored;
    done_nxt   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          stored_nxt = data_in;
          cnt_clr    = 1'b1;
          state_nxt  = ST_SHIFT;
        end else begin
          case (mode)
            MODE_LOAD: stored_nxt = data_in;
            MODE_SHL:  stored_nxt = {stored[WIDTH-2:0], ser_in_r};
            MODE_SHR:  stored_nxt = {ser_in_l, stored[WIDTH-1:1]};
            MODE_ROTL: stored_nxt = {stored[WIDTH-2:0], stored[WIDTH-1]};
            MODE_ROTR: stored_nxt = {stored[0], stored[WIDTH-1:1]};
            MODE_CLR:  stored_nxt = '0;
            default:   stored_nxt = stored;
          endcase
        end
      end
      ST_SHIFT: begin
        // Zero-fill so the register is empty once the last bit has left.
        stored_nxt = {1'b0, stored[WIDTH-1:1]};
        cnt_en     = 1'b1;
        if (cnt_tc) begin
          cnt_clr   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy    = (state == ST_SHIFT);
  assign ser_out = stored[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Randomised and directed checks of univ_shift_reg against a remaining-bits reference model.
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [2:0]   mode = '0;
  logic [W-1:0] data_in = '0;
  logic         ser_in_l = 1'b0, ser_in_r = 1'b0, start = 1'b0;
  logic [W-1:0] stored;
  logic         ser_out, busy, done;

  univ_shift_reg #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .mode     (mode),
    .data_in  (data_in),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .start    (start),
    .stored   (stored),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0, n_err = 0;

  // Reference: word plus number of serial bits still to go.
  logic [W-1:0] m_stored = '0;
  int           m_left = 0;
  logic         m_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stored = '0;
    m_left   = 0;
    m_done   = 1'b0;
  endtask

  task automatic model_step();
    if (!reset_n) model_reset();
    else if (m_left > 0) begin
      m_stored = m_stored >> 1;
      m_left   = m_left - 1;
      m_done   = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_stored = data_in;
        m_left   = W;
      end else begin
        case (mode)
          3'd1: m_stored = data_in;
          3'd2: m_stored = (m_stored << 1) | W'(ser_in_r);
          3'd3: m_stored = (m_stored >> 1) | (W'(ser_in_l) << (W - 1));
          3'd4: m_stored = (m_stored << 1) | (m_stored >> (W - 1));
          3'd5: m_stored = (m_stored >> 1) | (m_stored << (W - 1));
          3'd6: m_stored = '0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".stored"},  32'(stored),  32'(m_stored));
    chk({tag, ".ser_out"}, 32'(ser_out), 32'(m_stored[0]));
    chk({tag, ".busy"},    32'(busy),    32'(m_left > 0));
    chk({tag, ".done"},    32'(done),    32'(m_done));
  endtask

  task automatic cyc(input string tag);
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check_all(tag);
  endtask

  task automatic set_in(input logic st, input logic [2:0] md, input logic [W-1:0] d,
                        input logic sl, input logic sr);
    start = st; mode = md; data_in = d; ser_in_l = sl; ser_in_r = sr;
  endtask

  task automatic set_rand_idle_noise();
    set_in(1'b0, 3'($urandom_range(0, 7)), W'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Start a transfer of w, collect the stream, and end in the done cycle.
  task automatic run_ser(input string tag, input logic [W-1:0] w, input bit poke);
    logic [W-1:0] got;
    int bcnt;
    set_in(1'b1, 3'($urandom_range(0, 7)), w, 1'($urandom), 1'($urandom));
    cyc(tag);
    chk({tag, ".busy_rise"}, 32'(busy), 32'd1);
    got  = '0;
    bcnt = 0;
    for (int k = 0; k < W; k++) begin
      got[k] = ser_out;
      if (busy) bcnt++;
      if (poke && k == 3) set_in(1'b1, 3'd1, '1, 1'b1, 1'b1);
      else                set_rand_idle_noise();
      cyc(tag);
    end
    chk({tag, ".stream"}, 32'(got), 32'(w));
    chk({tag, ".busy_len"}, 32'(bcnt), 32'(W));
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
    chk({tag, ".empty"}, 32'(stored), 32'd0);
  endtask

  task automatic mode_op(input string tag, input logic [W-1:0] init, input logic [2:0] md,
                         input logic sl, input logic sr, input logic [W-1:0] exp);
    set_in(1'b0, 3'd1, init, 1'b0, 1'b0);
    cyc({tag, ".ld"});
    set_in(1'b0, md, ~init, sl, sr);
    cyc(tag);
    chk({tag, ".value"}, 32'(stored), 32'(exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(negedge Clk);
    check_all("por");
    reset_n = 1'b1;

    // Async reset mid-cycle after a load.
    set_in(1'b0, 3'd1, 8'hFF, 1'b0, 1'b0);
    cyc("load_ff");
    chk("load_ff.value", 32'(stored), 32'hFF);
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    chk("async_rst.stored", 32'(stored), 32'd0);
    set_in(1'b0, 3'd0, '0, 1'b0, 1'b0);
    cyc("rst_hold");
    cyc("rst_hold");
    reset_n = 1'b1;
    cyc("rst_rel");
    chk("rst_rel.stored", 32'(stored), 32'd0);

    mode_op("shl",  8'hA5, 3'd2, 1'b0, 1'b1, 8'h4B);
    mode_op("shr",  8'hA5, 3'd3, 1'b1, 1'b0, 8'hD2);
    mode_op("rotl", 8'h81, 3'd4, 1'b0, 1'b0, 8'h03);
    mode_op("rotr", 8'h81, 3'd5, 1'b0, 1'b0, 8'hC0);
    mode_op("clr",  8'hA5, 3'd6, 1'b1, 1'b1, 8'h00);
    mode_op("rsv",  8'h5A, 3'd7, 1'b1, 1'b1, 8'h5A);
    mode_op("hold", 8'h3C, 3'd0, 1'b1, 1'b1, 8'h3C);

    run_ser("ser_b4", 8'hB4, 1'b0);
    set_in(1'b0, 3'd0, '0, 1'b0, 1'b0);
    cyc("ser_idle");

    run_ser("ignore", 8'hB4, 1'b1);
    set_in(1'b0, 3'd0, '0, 1'b0, 1'b0);
    cyc("ignore_after");
    chk("ignore_after.busy", 32'(busy), 32'd0);

    run_ser("b2b_a", 8'hB4, 1'b0);
    run_ser("b2b_b", 8'h0F, 1'b0);
    set_in(1'b0, 3'd0, '0, 1'b0, 1'b0);
    cyc("b2b_idle");

    // Abort during bit 4 of an all-ones word.
    set_in(1'b1, 3'd0, 8'hFF, 1'b0, 1'b0);
    cyc("abort_start");
    for (int k = 0; k < 4; k++) begin
      set_in(1'b0, 3'd0, '0, 1'b0, 1'b0);
      cyc("abort_run");
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all("abort");
    chk("abort.stored", 32'(stored), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    cyc("abort_hold");
    reset_n = 1'b1;
    for (int k = 0; k < W + 2; k++) cyc("abort_nodone");
    run_ser("after_abort", 8'h3C, 1'b0);

    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), W'($urandom),
             1'($urandom), 1'($urandom));
      if ($urandom_range(0, 59) == 0) begin
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all("rand_rst");
        reset_n = 1'b1;
      end
      cyc("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
